// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax block.
// The runner-up/margin datapath is built only when ARGMAX_MARGIN_EN is defined.
package argmax_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } argmax_state_t;

    // Wide enough for any DATA_W this block is built with. Callers sign-extend
    // their operands in and truncate the result back to DATA_W.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_margin(
        input logic signed [SAT_W-1:0] max_v,
        input logic signed [SAT_W-1:0] second_v,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] diff;
        logic        [SAT_W-1:0] lim;
        diff = max_v - second_v;
        lim  = (SAT_W'(1) << data_w) - SAT_W'(1);
        if (diff < 0)
            return '0;
        else if ($unsigned(diff) > lim)
            return lim;
        return $unsigned(diff);
    endfunction

endpackage

// File: rtl/argmax_update.sv
// Combinational compare/update of the running maximum (and runner-up when
// ARGMAX_MARGIN_EN is defined) for one incoming score.
module argmax_update
    import argmax_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic                     first,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic        [IDX_W-1:0]  in_idx,
    input  logic signed [DATA_W-1:0] max_val,
    input  logic        [IDX_W-1:0]  max_idx,
`ifdef ARGMAX_MARGIN_EN
    input  logic signed [DATA_W-1:0] second_val,
    output logic signed [DATA_W-1:0] second_nxt,
`endif
    output logic signed [DATA_W-1:0] max_nxt,
    output logic        [IDX_W-1:0]  idx_nxt
);

    always_comb begin
        max_nxt = max_val;
        idx_nxt = max_idx;
`ifdef ARGMAX_MARGIN_EN
        second_nxt = second_val;
`endif
        if (first) begin
            max_nxt = in_data;
            idx_nxt = '0;
`ifdef ARGMAX_MARGIN_EN
            second_nxt = {1'b1, {(DATA_W-1){1'b0}}};
`endif
        end else if (in_data > max_val) begin
            // Strict compare: a tie never moves the index.
            max_nxt = in_data;
            idx_nxt = in_idx;
`ifdef ARGMAX_MARGIN_EN
            second_nxt = max_val;
        end else if (in_data > second_val) begin
            second_nxt = in_data;
`endif
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over fixed-length frames with valid/ready on both sides.
// Define ARGMAX_MARGIN_EN to build the runner-up tracker and out_margin.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = $clog2(N_CLASSES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] out_margin,
    output logic              out_frame_err,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    argmax_state_t            state_q, state_nxt;
    logic        [IDX_W-1:0]  cnt, max_idx, upd_idx;
    logic signed [DATA_W-1:0] max_val, upd_max;
    logic                     err_q, accept, at_last, last_bad;

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready && !clear;
    assign at_last   = (cnt == LAST_IDX);
    assign last_bad  = at_last ? !in_last : in_last;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0] second_val, upd_second;
`endif

    argmax_update #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_update (
        .first      (cnt == '0),
        .in_data    (in_data),
        .in_idx     (cnt),
        .max_val    (max_val),
        .max_idx    (max_idx),
`ifdef ARGMAX_MARGIN_EN
        .second_val (second_val),
        .second_nxt (upd_second),
`endif
        .max_nxt    (upd_max),
        .idx_nxt    (upd_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ACCUM;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ACCUM: if (accept && at_last) state_nxt = HOLD;
            HOLD:  if (out_ready)         state_nxt = ACCUM;
            default:                      state_nxt = ACCUM;
        endcase
        if (clear) state_nxt = ACCUM;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            max_val       <= '0;
            max_idx       <= '0;
            err_q         <= 1'b0;
            out_index     <= '0;
            out_value     <= '0;
            out_frame_err <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            max_val <= upd_max;
            max_idx <= upd_idx;
            if (at_last) begin
                cnt           <= '0;
                err_q         <= 1'b0;
                out_index     <= upd_idx;
                out_value     <= upd_max;
                out_frame_err <= err_q | last_bad;
            end else begin
                cnt   <= cnt + 1'b1;
                err_q <= err_q | last_bad;
            end
        end
    end

`ifdef ARGMAX_MARGIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            second_val <= '0;
            out_margin <= '0;
        end else if (accept && !clear) begin
            second_val <= upd_second;
            if (at_last)
                out_margin <= DATA_W'(sat_margin(SAT_W'(upd_max), SAT_W'(upd_second), DATA_W));
        end
    end
`else
    assign out_margin = '0;
`endif

endmodule

// File: tb/tb_argmax_stream.sv
// Randomised self-checking bench for argmax_stream against an array-based model.
// Margin expectations follow ARGMAX_MARGIN_EN when it is defined for the build.
module tb_argmax_stream;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, in_ready, in_last;
    logic          out_frame_err, out_valid, out_ready;
    logic [DW-1:0] in_data, out_value, out_margin;
    logic [IW-1:0] out_index;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    argmax_stream #(.N_CLASSES(N), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .out_index     (out_index),
        .out_value     (out_value),
        .out_margin    (out_margin),
        .out_frame_err (out_frame_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: first index of the maximum, runner-up = max of all other entries.
    function automatic void model(input int sc[N], input int lastmask,
                                  output int e_idx, output int e_val,
                                  output int e_margin, output int e_err);
        int sec;
        e_idx = 0;
        e_val = sc[0];
        for (int i = 1; i < N; i++)
            if (sc[i] > e_val) begin e_val = sc[i]; e_idx = i; end
        sec = -32768;
        for (int i = 0; i < N; i++)
            if (i != e_idx && sc[i] > sec) sec = sc[i];
`ifdef ARGMAX_MARGIN_EN
        e_margin = (e_val - sec > 65535) ? 65535 : e_val - sec;
`else
        e_margin = 0;
`endif
        e_err = 0;
        for (int i = 0; i < N; i++)
            if ((i == N-1) != lastmask[i]) e_err = 1;
    endfunction

    task automatic send_beat(input int d, input bit last, input bit final_beat);
        @(negedge clk);
        in_data  = DW'(d);
        in_valid = 1'b1;
        in_last  = last;
        if (final_beat) chk("pre_valid", 32'(out_valid), 0);
        for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
        chk("in_ready", 32'(in_ready), 1);
        @(posedge clk);
    endtask

    task automatic run_frame(input int sc[N], input int lastmask, input bit gaps, input string tag);
        int e_idx, e_val, e_margin, e_err;
        model(sc, lastmask, e_idx, e_val, e_margin, e_err);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_beat(sc[i], lastmask[i], i == N-1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_inrdy_hold"}, 32'(in_ready), 0);
        chk({tag, "_index"}, 32'(out_index), 32'(e_idx));
        chk({tag, "_value"}, 32'(out_value), 32'(e_val & 'hFFFF));
        chk({tag, "_margin"}, 32'(out_margin), 32'(e_margin));
        chk({tag, "_err"}, 32'(out_frame_err), 32'(e_err));
        if (out_ready) begin
            @(negedge clk);
            chk({tag, "_inrdy_next"}, 32'(in_ready), 1);
            chk({tag, "_valid_drop"}, 32'(out_valid), 0);
        end
    endtask

    function automatic void rand_frame(output int sc[N]);
        bit narrow = $urandom_range(0, 1) == 1;
        for (int i = 0; i < N; i++)
            sc[i] = narrow ? int'($urandom_range(0, 6)) - 3
                           : int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc[N];
        int e_idx, e_val, e_margin, e_err;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_index", 32'(out_index), 0);
        chk("rst_value", 32'(out_value), 0);
        chk("rst_margin", 32'(out_margin), 0);
        chk("rst_err", 32'(out_frame_err), 0);
        reset = 1'b0;

        sc = '{-5, 3, 7, 2, 7, -100, 0, 1, 6, 4};
        run_frame(sc, 1 << (N-1), 1'b0, "dir");
        chk("dir_idx_const", 32'(out_index), 2);
        chk("dir_val_const", 32'(out_value), 7);

        foreach (sc[i]) sc[i] = -32768;
        run_frame(sc, 1 << (N-1), 1'b0, "allneg");
        chk("allneg_val_const", 32'(out_value), 32'h8000);

        sc[0] = 32767;
        run_frame(sc, 1 << (N-1), 1'b0, "sat");
`ifdef ARGMAX_MARGIN_EN
        chk("sat_margin_const", 32'(out_margin), 32'hFFFF);
`endif

        // Backpressure: result must stay put while out_ready is low.
        out_ready = 1'b0;
        rand_frame(sc);
        model(sc, 1 << (N-1), e_idx, e_val, e_margin, e_err);
        run_frame(sc, 1 << (N-1), 1'b1, "bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_index", 32'(out_index), 32'(e_idx));
            chk("bp_value", 32'(out_value), 32'(e_val & 'hFFFF));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_inrdy", 32'(in_ready), 1);
        chk("bp_release_valid", 32'(out_valid), 0);
        rand_frame(sc);
        run_frame(sc, 1 << (N-1), 1'b0, "bp_next");

        rand_frame(sc);
        run_frame(sc, 1 << 4, 1'b0, "early_last");
        chk("early_last_err_const", 32'(out_frame_err), 1);
        rand_frame(sc);
        run_frame(sc, 1 << (N-1), 1'b0, "after_err");
        chk("after_err_const", 32'(out_frame_err), 0);
        run_frame(sc, 0, 1'b0, "no_last");

        // Clear after 7 beats; the beat offered alongside clear must be dropped.
        for (int i = 0; i < 7; i++) send_beat(50 + i, 1'b0, 1'b0);
        @(negedge clk);
        in_data = 16'd100; in_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_inrdy", 32'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("clr_no_valid", 32'(out_valid), 0);
        end
        foreach (sc[i]) sc[i] = i;
        run_frame(sc, 1 << (N-1), 1'b0, "clr_asc");
        chk("clr_asc_idx_const", 32'(out_index), 9);

        out_ready = 1'b0;
        rand_frame(sc);
        run_frame(sc, 1 << (N-1), 1'b0, "clr_hold");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_hold_valid", 32'(out_valid), 0);
        chk("clr_hold_inrdy", 32'(in_ready), 1);
        out_ready = 1'b1;

        // Asynchronous reset mid-frame, then in HOLD.
        for (int i = 0; i < 5; i++) send_beat(1000 - i, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_inrdy", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        rand_frame(sc);
        run_frame(sc, 1 << (N-1), 1'b1, "rst_mid_next");

        out_ready = 1'b0;
        rand_frame(sc);
        run_frame(sc, 1 << (N-1), 1'b0, "rst_hold");
        #2 reset = 1'b1;
        #1;
        chk("rst_hold_valid", 32'(out_valid), 0);
        chk("rst_hold_inrdy", 32'(in_ready), 1);
        chk("rst_hold_index", 32'(out_index), 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        rand_frame(sc);
        run_frame(sc, 1 << (N-1), 1'b0, "rst_hold_next");

        for (int f = 0; f < 20; f++) begin
            rand_frame(sc);
            run_frame(sc, ($urandom_range(0, 4) == 0) ? (1 << $urandom_range(0, N-1)) : (1 << (N-1)),
                      1'b1, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
